// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer constants and Gray conversion helpers,
// used by both the read-side and write-side pointer-exchange blocks.
package fifo_pkg;

    localparam int unsigned DEPTHSIZE   = 5;
    localparam int unsigned ADDRESSSIZE = 4;
    localparam int unsigned PTR_W       = DEPTHSIZE + 1;
    localparam int unsigned ADDR_W      = ADDRESSSIZE + 1;
    localparam int unsigned CAPACITY    = 1 << ADDR_W;

    typedef logic [PTR_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = int'(PTR_W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// N-stage synchronizer for a Gray-coded pointer crossing into clk.
// The last two stages are exposed so the consumer can check for multi-bit jumps.
module gray_sync #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned W      = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync_last,
    output logic [W-1:0] sync_prev
);

    logic [W-1:0] q [STAGES];

    // Plain flop chain; nothing may sit between stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                q[i] <= '0;
            end
        end else begin
            q[0] <= din;
            for (int i = 1; i < int'(STAGES); i++) begin
                q[i] <= q[i-1];
            end
        end
    end

    assign sync_last = q[STAGES-1];
    assign sync_prev = q[STAGES-2];

endmodule

// File: rtl/read_ptr_exchange.sv
// Read-domain pointer exchange: Gray-encodes the read pointer for the write
// domain, brings the write pointer into rclk, and derives level and error flags.
module read_ptr_exchange
    import fifo_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AE_THRESH   = 4
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [PTR_W-1:0] rptr,
    input  logic [PTR_W-1:0] wptr_gray_wclk,
    output logic [PTR_W-1:0] rptr_gray,
    output logic [PTR_W-1:0] wptr_rclk,
    output logic [PTR_W-1:0] rlevel,
    output logic             ralmost_empty,
    output logic             gray_jump_err,
    output logic             level_err
);

    localparam int unsigned MASK_W = $clog2(SYNC_STAGES + 2);

    logic [PTR_W-1:0]  sync_last;
    logic [PTR_W-1:0]  sync_prev;
    logic [PTR_W-1:0]  next_level;
    logic [MASK_W-1:0] mask_cnt;
    logic              jump;

    gray_sync #(
        .STAGES (SYNC_STAGES),
        .W      (PTR_W)
    ) u_gray_sync (
        .clk       (rclk),
        .rst_n     (rrst_n),
        .din       (wptr_gray_wclk),
        .sync_last (sync_last),
        .sync_prev (sync_prev)
    );

    // Jump check stays masked while the chain flushes after reset.
    always_comb begin
        next_level = wptr_rclk - rptr;
        jump       = (mask_cnt == '0) && ($countones(sync_last ^ sync_prev) > 1);
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rptr_gray <= '0;
            wptr_rclk <= '0;
        end else begin
            rptr_gray <= bin2gray(rptr);
            wptr_rclk <= gray2bin(sync_last);
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rlevel        <= '0;
            ralmost_empty <= 1'b1;
            level_err     <= 1'b0;
        end else begin
            rlevel        <= next_level;
            ralmost_empty <= (next_level <= PTR_W'(AE_THRESH));
            level_err     <= level_err | (next_level > PTR_W'(CAPACITY));
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            mask_cnt      <= MASK_W'(SYNC_STAGES + 1);
            gray_jump_err <= 1'b0;
        end else begin
            gray_jump_err <= gray_jump_err | jump;
            if (mask_cnt != '0) begin
                mask_cnt <= mask_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_read_ptr_exchange.sv
// Bench for read_ptr_exchange: directed test-plan steps plus random traffic,
// every cycle compared against a cycle-level behavioural model.
module tb_read_ptr_exchange;

    localparam int S  = 2;
    localparam int AE = 4;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic [5:0] rptr;
    logic [5:0] wptr_gray_wclk;
    logic [5:0] rptr_gray;
    logic [5:0] wptr_rclk;
    logic [5:0] rlevel;
    logic       ralmost_empty;
    logic       gray_jump_err;
    logic       level_err;

    int checks = 0;
    int errors = 0;

    read_ptr_exchange #(
        .SYNC_STAGES (S),
        .AE_THRESH   (AE)
    ) dut (
        .rclk           (rclk),
        .rrst_n         (rrst_n),
        .rptr           (rptr),
        .wptr_gray_wclk (wptr_gray_wclk),
        .rptr_gray      (rptr_gray),
        .wptr_rclk      (wptr_rclk),
        .rlevel         (rlevel),
        .ralmost_empty  (ralmost_empty),
        .gray_jump_err  (gray_jump_err),
        .level_err      (level_err)
    );

    always #5 rclk = ~rclk;

    // Reference model state
    logic [5:0] dq[$];
    int         m_rel;
    logic [5:0] m_rgray, m_wptr, m_level;
    logic       m_ae, m_jerr, m_lerr;

    function automatic logic [5:0] gray(input int v);
        return 6'(v ^ (v >> 1));
    endfunction

    // Decode by search: the binary value whose Gray code matches.
    function automatic logic [5:0] ungray(input logic [5:0] g);
        for (int b = 0; b < 64; b++) begin
            if (gray(b) == g) return 6'(b);
        end
        return 6'd0;
    endfunction

    task automatic model_edge(input logic rst, input logic [5:0] rp, input logic [5:0] wg);
        logic [5:0] lvl;
        logic       jmp;
        if (!rst) begin
            dq.delete();
            for (int i = 0; i < S; i++) dq.push_back(6'd0);
            m_rel = 0;
            m_rgray = '0; m_wptr = '0; m_level = '0;
            m_ae = 1'b1; m_jerr = 1'b0; m_lerr = 1'b0;
        end else begin
            m_rel++;
            jmp     = (m_rel >= S + 2) && ($countones(dq[0] ^ dq[1]) > 1);
            lvl     = 6'(m_wptr - rp);
            m_level = lvl;
            m_ae    = (int'(lvl) <= AE);
            m_lerr  = m_lerr | (int'(lvl) > 32);
            m_jerr  = m_jerr | jmp;
            m_wptr  = ungray(dq[0]);
            m_rgray = gray(int'(rp));
            void'(dq.pop_front());
            dq.push_back(wg);
        end
    endtask

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [5:0] rp, input logic [5:0] wg);
        rrst_n         = rst;
        rptr           = rp;
        wptr_gray_wclk = wg;
        @(posedge rclk);
        model_edge(rst, rp, wg);
        #1;
        chk("rptr_gray", rptr_gray, m_rgray);
        chk("wptr_rclk", wptr_rclk, m_wptr);
        chk("rlevel", rlevel, m_level);
        chk("ralmost_empty", 6'(ralmost_empty), 6'(m_ae));
        chk("gray_jump_err", 6'(gray_jump_err), 6'(m_jerr));
        chk("level_err", 6'(level_err), 6'(m_lerr));
    endtask

    initial begin
        int w, r;
        logic [5:0] wg;
        int seq[5];
        seq = '{62, 63, 0, 1, 2};

        // Reset then idle at zero
        step(0, 0, 0);
        step(0, 0, 0);
        chk("reset_ae", 6'(ralmost_empty), 6'd1);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        chk("idle_level", rlevel, 6'd0);

        // Walk write pointer 1..6
        for (int v = 1; v <= 6; v++) begin
            for (int k = 0; k < 4; k++) step(1, 0, gray(v));
        end
        for (int k = 0; k < 4; k++) step(1, 0, gray(6));
        chk("walk_wptr", wptr_rclk, 6'd6);
        chk("walk_level", rlevel, 6'd6);
        chk("walk_ae", 6'(ralmost_empty), 6'd0);

        // Wrap-around through 63 -> 0
        step(0, 62, gray(62));
        step(0, 62, gray(62));
        foreach (seq[j]) begin
            for (int k = 0; k < 4; k++) step(1, 62, gray(seq[j]));
        end
        for (int k = 0; k < 4; k++) step(1, 62, gray(2));
        chk("wrap_level", rlevel, 6'd4);
        chk("wrap_rgray", rptr_gray, 6'b100001);
        chk("wrap_jerr", 6'(gray_jump_err), 6'd0);

        // Single-bit step 3 -> 12 is legal, then a multi-bit jump
        for (int k = 0; k < 4; k++) step(1, 0, gray(3));
        for (int k = 0; k < 4; k++) step(1, 0, gray(12));
        chk("legal_step_jerr", 6'(gray_jump_err), 6'd0);
        for (int k = 0; k < 6; k++) step(1, 0, 6'b110101);
        chk("jump_jerr", 6'(gray_jump_err), 6'd1);

        // Overfull level, then a one-cycle reset mid-stream
        for (int k = 0; k < 6; k++) step(1, 0, gray(33));
        chk("over_level", rlevel, 6'd33);
        chk("over_lerr", 6'(level_err), 6'd1);
        chk("still_jerr", 6'(gray_jump_err), 6'd1);
        step(0, 0, gray(20));
        chk("mid_rst_level", rlevel, 6'd0);
        chk("mid_rst_jerr", 6'(gray_jump_err), 6'd0);
        chk("mid_rst_lerr", 6'(level_err), 6'd0);

        // Release with a nonzero pointer already present
        for (int k = 0; k < S + 1; k++) step(1, 0, gray(20));
        chk("release_wptr", wptr_rclk, 6'd20);
        for (int k = 0; k < 4; k++) step(1, 0, gray(20));
        chk("release_jerr", 6'(gray_jump_err), 6'd0);

        // Random traffic with occasional resets and illegal jumps
        w = 20;
        r = 0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                w = $urandom_range(0, 63);
                r = w;
                step(0, 6'(r), gray(w));
            end else begin
                if ($urandom_range(0, 1) == 1 && ((w - r + 64) % 64) < 34) w = (w + 1) % 64;
                if (r != w && $urandom_range(0, 1) == 1) r = (r + 1) % 64;
                wg = ($urandom_range(0, 149) == 0) ? 6'($urandom_range(0, 63)) : gray(w);
                step(1, 6'(r), wg);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
